// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte lanes plus the UART data write port.
//   master : requesters and UART side (drives req_*, uart_wait)
//   slave  : arbiter side (drives req_ready, grant, uart_we, uart_di)
// Lane i of req_data is bits [8i+7:8i].
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              uart_we;
    logic [31:0]       uart_di;
    logic              uart_wait;

    modport master (
        output req_valid, req_data, req_last, uart_wait,
        input  req_ready, grant, uart_we, uart_di
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_wait,
        output req_ready, grant, uart_we, uart_di
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter sharing the UART
// transmit data register between NREQ byte requesters.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : req_valid/req_data/req_last/req_ready/grant per requester,
//                 uart_we/uart_di/uart_wait towards the UART
//   busy        : arbiter is not IDLE
// Optional macro UART_ARB_TIMEOUT_EN: releases a lock whose owner has
// withheld valid for TIMEOUT cycles; without it TIMEOUT is unused.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    uart_tx_arbiter_if.slave  bus,
    output logic              busy
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOCK, SEND} state_t;

    // Elaboration-time parameter range guards
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be 2..65535");
    end

    state_t          state_q, state_n;
    logic [OW-1:0]   owner_q, owner_n;
    logic [OW-1:0]   ptr_q, ptr_n;
    logic [7:0]      hold_byte_q, hold_byte_n;
    logic            hold_last_q, hold_last_n;
    logic [NREQ-1:0] ready_q, ready_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic            we_q, we_n;
    logic            busy_q, busy_n;

    logic [OW-1:0]   pick;
    logic            pick_vld;
    logic [OW-1:0]   next_owner;
    logic [7:0]      owner_byte;
    logic            owner_valid;
    logic            owner_last;
    logic            to_hit;
    logic [NREQ-1:0] owner_oh_n;

    // Only the owner's lane is ever sampled
    assign owner_byte  = bus.req_data[{owner_q, 3'b000} +: 8];
    assign owner_valid = bus.req_valid[owner_q];
    assign owner_last  = bus.req_last[owner_q];
    assign next_owner  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    // First valid requester at or after ptr, wrapping
    always_comb begin
        int unsigned idx;
        logic [OW-1:0] idx_w;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx   = (32'(ptr_q) + i) % NREQ;
            idx_w = OW'(idx);
            if (!pick_vld && bus.req_valid[idx_w]) begin
                pick     = idx_w;
                pick_vld = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Counts owner-idle LOCK cycles; any handshake or exit from LOCK clears it
    logic [15:0] to_cnt_q, to_cnt_n;

    assign to_hit = (state_q == LOCK) && !owner_valid &&
                    (to_cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        to_cnt_n = '0;
        if (state_q == LOCK && !owner_valid && !to_hit) begin
            to_cnt_n = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_n;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next state; outputs are derived from the next state and then registered
    always_comb begin
        state_n     = state_q;
        owner_n     = owner_q;
        ptr_n       = ptr_q;
        hold_byte_n = hold_byte_q;
        hold_last_n = hold_last_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_n = pick;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                if (owner_valid) begin
                    hold_byte_n = owner_byte;
                    hold_last_n = owner_last;
                    state_n     = SEND;
                end else if (to_hit) begin
                    state_n = IDLE;
                    ptr_n   = next_owner;
                end
            end
            SEND: begin
                if (!bus.uart_wait) begin
                    if (hold_last_q) begin
                        state_n = IDLE;
                        ptr_n   = next_owner;
                    end else begin
                        state_n = LOCK;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        owner_oh_n = NREQ'(1) << owner_n;
        ready_n    = (state_n == LOCK) ? owner_oh_n : '0;
        grant_n    = (state_n != IDLE) ? owner_oh_n : '0;
        we_n       = (state_n == SEND);
        busy_n     = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_byte_q <= '0;
            hold_last_q <= 1'b0;
            ready_q     <= '0;
            grant_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            owner_q     <= owner_n;
            ptr_q       <= ptr_n;
            hold_byte_q <= hold_byte_n;
            hold_last_q <= hold_last_n;
            ready_q     <= ready_n;
            grant_q     <= grant_n;
            we_q        <= we_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.grant     = grant_q;
    assign bus.uart_we   = we_q;
    assign bus.uart_di   = {24'h0, hold_byte_q};
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a message-level round-robin model (per-requester byte queues,
// owner and pointer tracked per accepted UART write).
module tb_uart_tx_arbiter;
    localparam int unsigned N = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic busy;

    uart_tx_arbiter_if #(.NREQ(N)) bus ();

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic [8:0]  stim_q [N][$];
    logic [8:0]  mod_q  [N][$];
    logic [7:0]  sent_q [$];
    int          own_q  [$];
    bit          mid    [N];
    bit          gap_en   = 1'b0;
    bit          model_en = 1'b1;
    int unsigned wait_pct = 0;
    int          m_owner  = -1;
    int          m_ptr    = 0;
    int unsigned accepts  = 0;
    int unsigned we_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input bit last);
        stim_q[r].push_back({last, b});
        mod_q[r].push_back({last, b});
    endtask

    function automatic int unsigned pending();
        int unsigned s = 0;
        for (int i = 0; i < N; i++) s += mod_q[i].size();
        return s;
    endfunction

    task automatic clear_logs();
        sent_q.delete();
        own_q.delete();
        accepts   = 0;
        we_cycles = 0;
    endtask

    // Reference: next message goes to the first requester with queued bytes
    // at or after the pointer; bytes of a message come strictly in order.
    task automatic model_accept();
        logic [8:0] e;
        int o;
        o = m_owner;
        if (o < 0) begin
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (m_ptr + k) % int'(N);
                if (o < 0 && mod_q[j].size() > 0) o = j;
            end
        end
        if (o < 0) begin
            chk("spurious_accept", 32'(bus.uart_we), 32'(0));
        end else begin
            e = mod_q[o].pop_front();
            chk("owner_grant", 32'(bus.grant), 32'(1 << o));
            chk("uart_di", bus.uart_di, {24'h0, e[7:0]});
            if (e[8]) begin
                m_owner = -1;
                m_ptr   = (o + 1) % int'(N);
            end else begin
                m_owner = o;
            end
        end
    endtask

    // One clock: entered and left at a negedge
    task automatic step();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        logic [8:0]     e;
        logic           w;
        int             g;
        for (int i = 0; i < int'(N); i++) begin
            if (stim_q[i].size() > 0 && !(gap_en && mid[i] && $urandom_range(99) < 20)) begin
                e = stim_q[i][0];
                v[i] = 1'b1;
                d[8*i +: 8] = e[7:0];
                l[i] = e[8];
            end else begin
                v[i] = 1'b0;
                d[8*i +: 8] = 8'($urandom);
                l[i] = 1'($urandom);
            end
        end
        w = ($urandom_range(99) < wait_pct);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.uart_wait = w;
        if (model_en) begin
            chk("grant_onehot0", 32'($countones(bus.grant) <= 1), 32'(1));
            chk("ready_only_owner", 32'(bus.req_ready & ~bus.grant), 32'(0));
        end
        for (int i = 0; i < int'(N); i++) begin
            if (bus.req_ready[i] && v[i]) begin
                e = stim_q[i].pop_front();
                mid[i] = !e[8];
            end
        end
        if (bus.uart_we) we_cycles++;
        if (bus.uart_we && !w) begin
            accepts++;
            g = -1;
            for (int i = 0; i < int'(N); i++) if (bus.grant[i]) g = i;
            sent_q.push_back(bus.uart_di[7:0]);
            own_q.push_back(g);
            if (model_en) model_accept();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned cyc = 0;
        while ((pending() > 0 || busy) && cyc < budget) begin
            step();
            cyc++;
        end
        chk("drain_left", 32'(pending()), 32'(0));
        chk("drain_idle", 32'(busy), 32'(0));
    endtask

    // Called at a negedge; returns at the negedge after reset was sampled
    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.uart_wait = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            stim_q[i].delete();
            mod_q[i].delete();
            mid[i] = 1'b0;
        end
        m_owner = -1;
        m_ptr   = 0;
    endtask

    initial begin
        int unsigned total;
        int unsigned cyc;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.uart_wait = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_we",    32'(bus.uart_we), 32'(0));
        chk("rst_di",    bus.uart_di, 32'(0));
        chk("rst_busy",  32'(busy), 32'(0));

        // Single message from req0
        clear_logs();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        step();
        chk("t1_first_ready", 32'(bus.req_ready), 32'h1);
        chk("t1_first_grant", 32'(bus.grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'(1));
        drain(200);
        chk("t1_count", 32'(sent_q.size()), 32'(3));
        chk("t1_b0", 32'(sent_q[0]), 32'h41);
        chk("t1_b1", 32'(sent_q[1]), 32'h42);
        chk("t1_b2", 32'(sent_q[2]), 32'h43);
        chk("t1_we_cycles", 32'(we_cycles), 32'(3));
        chk("t1_grant_after", 32'(bus.grant), 32'(0));

        // Non-interleaving: req1 and req3 together
        clear_logs();
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b1);
        push(3, 8'h30, 1'b0);
        push(3, 8'h31, 1'b1);
        drain(200);
        chk("t2_count", 32'(sent_q.size()), 32'(4));
        chk("t2_b0", 32'(sent_q[0]), 32'h10);
        chk("t2_b1", 32'(sent_q[1]), 32'h11);
        chk("t2_b2", 32'(sent_q[2]), 32'h30);
        chk("t2_b3", 32'(sent_q[3]), 32'h31);

        // Round robin: everyone keeps 1-byte messages queued
        clear_logs();
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < int'(N); r++)
                push(r, 8'(8'h80 + 16 * rep + r), 1'b1);
        drain(200);
        for (int k = 0; k < 8; k++) chk("t3_order", 32'(own_q[k]), 32'(k % 4));

        // UART back-pressure for 500 cycles on byte 0x55
        clear_logs();
        push(2, 8'h55, 1'b1);
        wait_pct = 100;
        cyc = 0;
        while (!bus.uart_we && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t4_we_rise", 32'(bus.uart_we), 32'(1));
        for (int k = 0; k < 500; k++) begin
            chk("t4_we_held", 32'(bus.uart_we), 32'(1));
            chk("t4_di_held", bus.uart_di, 32'h55);
            chk("t4_ready_low", 32'(bus.req_ready), 32'(0));
            step();
        end
        chk("t4_no_accept_yet", 32'(accepts), 32'(0));
        wait_pct = 0;
        drain(50);
        chk("t4_single_accept", 32'(accepts), 32'(1));
        chk("t4_we_cycles", 32'(we_cycles), 32'(501));

        // Reset while in SEND
        clear_logs();
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        wait_pct = 100;
        cyc = 0;
        while (!bus.uart_we && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t5_in_send", 32'(bus.uart_we), 32'(1));
        wait_pct = 0;
        do_reset();
        chk("t5_we",    32'(bus.uart_we), 32'(0));
        chk("t5_grant", 32'(bus.grant), 32'(0));
        chk("t5_busy",  32'(busy), 32'(0));
        chk("t5_ready", 32'(bus.req_ready), 32'(0));
        clear_logs();
        push(2, 8'hC0, 1'b1);
        push(3, 8'hD0, 1'b1);
        drain(100);
        chk("t5_first_owner", 32'(own_q[0]), 32'(2));
        chk("t5_second_owner", 32'(own_q[1]), 32'(3));
        chk("t5_first_byte", 32'(sent_q[0]), 32'hC0);

        // Owner stalls mid-message while req1 waits
        clear_logs();
        model_en = 1'b0;
        push(0, 8'h77, 1'b0);
        push(1, 8'h20, 1'b1);
        cyc = 0;
        while (accepts == 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("t6_byte_sent", 32'(accepts), 32'(1));
        chk("t6_ready_back", 32'(bus.req_ready), 32'h1);
        for (int k = 0; k < 16; k++) begin
            chk("t6_lock_hold", 32'(bus.grant), 32'h1);
            step();
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("t6_released", 32'(bus.grant), 32'(0));
        step();
        chk("t6_new_grant", 32'(bus.grant), 32'h2);
        chk("t6_new_ready", 32'(bus.req_ready), 32'h2);
`else
        for (int k = 0; k < 100; k++) begin
            chk("t6_lock_kept", 32'(bus.grant), 32'h1);
            step();
        end
`endif
        model_en = 1'b1;
        do_reset();

        // Randomized traffic with owner gaps and UART stalls
        gap_en = 1'b1;
        for (int round = 0; round < 3; round++) begin
            wait_pct = 30 * round;
            clear_logs();
            total = 0;
            for (int r = 0; r < int'(N); r++) begin
                int nm;
                nm = int'($urandom_range(3, 6));
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) begin
                        push(r, 8'($urandom), b == len - 1);
                        total++;
                    end
                end
            end
            drain(20000);
            chk("rnd_accepts", 32'(accepts), 32'(total));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
